// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// State encoding, port indices and one-hot grant codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_DMA  = 2'b10;

  // One-hot grant to port index (valid only when a grant is set).
  function automatic logic gnt_idx(logic [1:0] g);
    return g[1];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester port bundle (req/we/lock/addr/wdata -> ack/rdata)
// and memory-side bundle (cs/we/addr/wdata -> rdata).
interface mem_arb_req_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic          lock;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  ack, rdata
  );
  modport slave (
    input  req, we, lock, addr, wdata,
    output ack, rdata
  );
endinterface

interface mem_arb_mem_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  logic          cs;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (
    output cs, we, addr, wdata,
    input  rdata
  );
  modport slave (
    input  cs, we, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker.
// req_i/mask_i/last_i (last served index) -> one-hot gnt_o.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  logic [1:0] eff;
  assign eff = req_i & ~mask_i;

  always_comb begin
    gnt_o = GNT_NONE;
    unique case (1'b1)
      (eff == 2'b11): gnt_o = last_i ? GNT_CPU : GNT_DMA;
      (eff == 2'b01): gnt_o = GNT_CPU;
      (eff == 2'b10): gnt_o = GNT_DMA;
      default:        gnt_o = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port memory: CPU (p0), DMA (p1).
// Ports: CLK, RST_N, p0/p1 requester bundles, mem bundle, GNT, BUSY.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 7,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  mem_arb_req_if.slave  p0,
  mem_arb_req_if.slave  p1,
  mem_arb_mem_if.master mem,
  output logic [1:0]    GNT,
  output logic          BUSY
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

  state_e        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rd0_q, rd0_d;
  logic [DW-1:0] rd1_q, rd1_d;

  logic [1:0]    req, we_in, lock_in;
  logic [AW-1:0] addr_in [2];
  logic [DW-1:0] wdata_in [2];
  logic [1:0]    mask, pick, win;
  logic          own, keep, arb;

  assign req[PORT_CPU]      = p0.req;
  assign req[PORT_DMA]      = p1.req;
  assign we_in[PORT_CPU]    = p0.we;
  assign we_in[PORT_DMA]    = p1.we;
  assign lock_in[PORT_CPU]  = p0.lock;
  assign lock_in[PORT_DMA]  = p1.lock;
  assign addr_in[PORT_CPU]  = p0.addr;
  assign addr_in[PORT_DMA]  = p1.addr;
  assign wdata_in[PORT_CPU] = p0.wdata;
  assign wdata_in[PORT_DMA] = p1.wdata;

  assign own = gnt_idx(gnt_q);
  assign arb = (state_q != ACCESS);

  // Locked owner keeps the grant unless its budget is spent
  // while the other port is waiting.
  assign keep = (state_q == RESP) & lock_in[own] & req[own]
              & ((cnt_q < LOCK_MAX) | ~req[~own]);

  // The owner's REQ is still high in RESP for the access just done.
  assign mask = (state_q == RESP) ? gnt_q : GNT_NONE;

  rr_pick2 u_pick (
    .req_i  (req),
    .mask_i (mask),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  assign win = keep ? gnt_q : pick;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gnt_q   <= GNT_NONE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|win) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = (|win) ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    if (arb) begin
      gnt_d = win;
      cnt_d = '0;
      if (keep) begin
        cnt_d = (cnt_q == LOCK_MAX) ? cnt_q : cnt_q + CW'(1);
      end
      if (|win) begin
        last_d  = gnt_idx(win);
        we_d    = we_in[gnt_idx(win)];
        addr_d  = addr_in[gnt_idx(win)];
        wdata_d = wdata_in[gnt_idx(win)];
      end
    end
    if (state_q == ACCESS && !we_q) begin
      if (gnt_q[PORT_CPU]) rd0_d = mem.rdata;
      else                 rd1_d = mem.rdata;
    end
  end

  always_comb begin
    mem.cs    = (state_q == ACCESS);
    mem.we    = (state_q == ACCESS) & we_q;
    mem.addr  = addr_q;
    mem.wdata = wdata_q;
    p0.ack    = (state_q == RESP) & gnt_q[PORT_CPU];
    p1.ack    = (state_q == RESP) & gnt_q[PORT_DMA];
    p0.rdata  = rd0_q;
    p1.rdata  = rd1_q;
    GNT       = gnt_q;
    BUSY      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps plus random traffic
// checked against a transaction-level memory/queue model.
module tb_mem_port_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int ML = 4;
  localparam int QD = 1024;

  typedef struct packed {
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arb_req_if #(.AW(AW), .DW(DW)) p0 ();
  mem_arb_req_if #(.AW(AW), .DW(DW)) p1 ();
  mem_arb_mem_if #(.AW(AW), .DW(DW)) mem ();
  logic [1:0] gnt;
  logic       busy;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(ML)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .p0    (p0),
    .p1    (p1),
    .mem   (mem),
    .GNT   (gnt),
    .BUSY  (busy)
  );

  function automatic logic [DW-1:0] init_val(int a);
    if (a == 5) return 32'h2002000A;
    return 32'h1000_0000 + 32'(a) * 32'h0001_0101;
  endfunction

  logic [DW-1:0] ram [128];
  logic          ram_ok;

  // Memory acts on the negedge inside the CS cycle.
  always @(negedge clk) begin
    if (ram_ok !== 1'b1) begin
      for (int i = 0; i < 128; i++) ram[i] <= init_val(i);
      ram_ok <= 1'b1;
    end else if (mem.cs === 1'b1) begin
      if (mem.we) ram[mem.addr] <= mem.wdata;
      else        mem.rdata <= ram[mem.addr];
    end
  end

  op_t           ops [2][QD];
  int            head [2];
  int            tail [2];
  int            waitc [2];
  logic [DW-1:0] ref_mem [128];
  logic [DW-1:0] last_rd [2];
  int            checks, errors;
  int            total_cs, total_acks;
  logic          cs_prev;
  int            streak, last_ack_port, ack_port, ack_wait;
  logic          s_cs, s_we, s_busy;
  logic [1:0]    s_ack, s_gnt;
  logic [DW-1:0] s_rd [2];
  logic [31:0]   seq;
  int            n, c0, a0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(int p, logic r, op_t o);
    if (p == 0) begin
      p0.req = r; p0.we = o.we; p0.lock = o.lock;
      p0.addr = o.addr; p0.wdata = o.wdata;
    end else begin
      p1.req = r; p1.we = o.we; p1.lock = o.lock;
      p1.addr = o.addr; p1.wdata = o.wdata;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      op_t o;
      o = '0;
      if (head[i] < tail[i]) begin
        o = ops[i][head[i]];
        set_port(i, 1'b1, o);
      end else begin
        set_port(i, 1'b0, o);
      end
    end
  endtask

  task automatic enq(int p, logic we, logic lk,
                     logic [AW-1:0] a, logic [DW-1:0] d);
    op_t o;
    o.we = we; o.lock = lk; o.addr = a; o.wdata = d;
    if (head[p] == tail[p]) waitc[p] = 0;
    ops[p][tail[p]] = o;
    tail[p]++;
  endtask

  task automatic clear_sb();
    for (int i = 0; i < 2; i++) begin
      head[i] = 0; tail[i] = 0; waitc[i] = 0;
      last_rd[i] = '0;
    end
    cs_prev = 1'b0; streak = 0; last_ack_port = -1;
    total_cs = 0; total_acks = 0;
  endtask

  function automatic int pending();
    return (tail[0] - head[0]) + (tail[1] - head[1]);
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    s_cs = mem.cs; s_we = mem.we; s_busy = busy; s_gnt = gnt;
    s_ack = {p1.ack, p0.ack};
    s_rd[0] = p0.rdata; s_rd[1] = p1.rdata;
    ack_port = -1;
    for (int i = 0; i < 2; i++)
      if (head[i] < tail[i]) waitc[i]++;
    chk("ack_excl", 32'(s_ack == 2'b11), 32'd0);
    chk("cs_gap", 32'(s_cs & cs_prev), 32'd0);
    chk("busy", 32'(s_busy), 32'(s_cs | (|s_ack)));
    chk("gnt_idle", 32'(s_gnt == 2'b00), 32'(!s_busy));
    cs_prev = s_cs;
    if (s_cs) total_cs++;
    for (int i = 0; i < 2; i++) begin
      if (s_ack[i]) begin
        op_t o;
        int other;
        other = 1 - i;
        total_acks++;
        chk("ack_gnt", 32'(s_gnt[i]), 32'd1);
        chk("ack_pending", 32'(head[i] < tail[i]), 32'd1);
        if (head[i] < tail[i]) begin
          o = ops[i][head[i]];
          if (o.we) begin
            ref_mem[o.addr] = o.wdata;
            chk("rd_hold_w", s_rd[i], last_rd[i]);
          end else begin
            chk("rdata", s_rd[i], ref_mem[o.addr]);
            last_rd[i] = ref_mem[o.addr];
          end
          chk("latency", 32'(waitc[i] <= 14), 32'd1);
          if (head[other] < tail[other] && waitc[other] >= 2)
            streak = (last_ack_port == i) ? streak + 1 : 1;
          else
            streak = 1;
          chk("fair", 32'(streak <= ML + 1), 32'd1);
          last_ack_port = i;
          ack_wait = waitc[i];
          head[i]++;
          waitc[i] = 0;
        end
        ack_port = i;
      end else begin
        chk("rd_hold", s_rd[i], last_rd[i]);
      end
    end
    drive();
  endtask

  initial begin
    checks = 0; errors = 0; ack_wait = 0;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
    clear_sb();
    drive();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cs", 32'(mem.cs), 32'd0);
    chk("rst_we", 32'(mem.we), 32'd0);
    chk("rst_addr", 32'(mem.addr), 32'd0);
    chk("rst_wdata", mem.wdata, 32'd0);
    chk("rst_ack", 32'({p1.ack, p0.ack}), 32'd0);
    chk("rst_rd0", p0.rdata, 32'd0);
    chk("rst_rd1", p1.rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single P0 read of word 5
    enq(0, 1'b0, 1'b0, 7'h05, 32'd0);
    drive();
    cycle();
    chk("t1_gnt_acc", 32'(s_gnt), 32'h1);
    chk("t1_cs", 32'(s_cs), 32'd1);
    chk("t1_addr", 32'(mem.addr), 32'h05);
    chk("t1_ack_early", 32'(s_ack), 32'd0);
    cycle();
    chk("t1_ack", 32'(s_ack), 32'h1);
    chk("t1_rdata", s_rd[0], 32'h2002000A);
    chk("t1_lat", 32'(ack_wait), 32'd2);
    chk("t1_cs_resp", 32'(s_cs), 32'd0);
    cycle();
    chk("t1_gnt_idle", 32'(s_gnt), 32'd0);

    // simultaneous requests, P0 served last
    enq(0, 1'b0, 1'b0, 7'h06, 32'd0);
    enq(1, 1'b0, 1'b0, 7'h07, 32'd0);
    drive();
    cycle();
    chk("t2_gnt_p1", 32'(s_gnt), 32'h2);
    cycle();
    chk("t2_ack_p1", 32'(s_ack), 32'h2);
    cycle();
    chk("t2_gnt_p0", 32'(s_gnt), 32'h1);
    chk("t2_no_ack", 32'(s_ack), 32'd0);
    cycle();
    chk("t2_ack_p0", 32'(s_ack), 32'h1);
    cycle();
    chk("t2_idle", 32'(s_busy), 32'd0);

    // P1 writes 0x7F, then P0 reads it back
    enq(1, 1'b1, 1'b0, 7'h7F, 32'hDEADBEEF);
    drive();
    repeat (3) cycle();
    enq(0, 1'b0, 1'b0, 7'h7F, 32'd0);
    drive();
    cycle();
    cycle();
    chk("t3_ack", 32'(s_ack), 32'h1);
    chk("t3_rdata", s_rd[0], 32'hDEADBEEF);
    cycle();

    // P1 locked burst of 6 writes against a waiting P0
    for (int k = 0; k < 6; k++)
      enq(1, 1'b1, 1'b1, 7'(7'h20 + k), $urandom);
    drive();
    cycle();
    chk("t4_first", 32'(s_gnt), 32'h2);
    enq(0, 1'b0, 1'b0, 7'h20, 32'd0);
    drive();
    seq = '0; n = 0;
    for (int k = 0; k < 40 && pending() > 0; k++) begin
      cycle();
      if (ack_port >= 0) begin
        seq = (seq << 1) | 32'(ack_port);
        n++;
      end
    end
    chk("t4_count", 32'(n), 32'd7);
    chk("t4_order", seq, 32'b1111101);
    repeat (2) cycle();

    // reset during a write ACCESS, before the negedge
    enq(1, 1'b1, 1'b0, 7'h30, 32'h12345678);
    drive();
    cycle();
    chk("t5_cs", 32'(s_cs), 32'd1);
    chk("t5_we", 32'(s_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_cs_drop", 32'(mem.cs), 32'd0);
    chk("t5_we_drop", 32'(mem.we), 32'd0);
    chk("t5_gnt", 32'(gnt), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ack", 32'({p1.ack, p0.ack}), 32'd0);
    clear_sb();
    drive();
    @(negedge clk);
    @(negedge clk);
    chk("t5_ram", ram[7'h30], init_val(8'h30));
    rst_n = 1'b1;
    cycle();
    chk("t5_idle", 32'(s_busy), 32'd0);
    enq(0, 1'b0, 1'b0, 7'h30, 32'd0);
    drive();
    cycle();
    chk("t5_regrant", 32'(s_gnt), 32'h1);
    cycle();
    chk("t5_ack_after", 32'(s_ack), 32'h1);
    cycle();

    // continuous unlocked P0 traffic
    c0 = total_cs; a0 = total_acks;
    for (int k = 0; k < 4; k++)
      enq(0, 1'b0, 1'b0, 7'($urandom_range(0, 127)), 32'd0);
    drive();
    for (int k = 0; k < 30 && pending() > 0; k++) cycle();
    chk("t6_cs", 32'(total_cs - c0), 32'd4);
    chk("t6_acks", 32'(total_acks - a0), 32'd4);

    // random traffic on both ports
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (tail[p] - head[p] < 3 && tail[p] < QD - 4
            && $urandom_range(0, 2) == 0)
          enq(p, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) == 0),
              7'(7'h60 + $urandom_range(0, 15)), $urandom);
      end
      drive();
      cycle();
    end
    for (int k = 0; k < 200 && pending() > 0; k++) cycle();
    chk("drain", 32'(pending()), 32'd0);
    repeat (3) cycle();
    chk("cs_per_ack", 32'(total_cs), 32'(total_acks));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
